// File: rtl/tlp_route_demux_if.sv
// Ingress/egress TLP stream bundle for tlp_route_demux.
//   in_*      : single ingress stream (data, header, sop/eop, valid/ready)
//   out_*     : PORTS egress streams, port p at slice [p*W +: W]
//   slave     : seen by the demux; master : seen by the source/sinks
interface tlp_route_demux_if #(
    parameter int unsigned PORTS        = 4,
    parameter int unsigned HEADER_SIZE  = 128,
    parameter int unsigned PAYLOAD_SIZE = 256
);
    logic [PAYLOAD_SIZE-1:0]       in_data;
    logic [HEADER_SIZE-1:0]        in_hdr;
    logic                          in_sop;
    logic                          in_eop;
    logic                          in_valid;
    logic                          in_ready;

    logic [PORTS*PAYLOAD_SIZE-1:0] out_data;
    logic [PORTS*HEADER_SIZE-1:0]  out_hdr;
    logic [PORTS-1:0]              out_sop;
    logic [PORTS-1:0]              out_eop;
    logic [PORTS-1:0]              out_valid;
    logic [PORTS-1:0]              out_ready;

    modport master (
        output in_data, in_hdr, in_sop, in_eop, in_valid,
        input  in_ready,
        input  out_data, out_hdr, out_sop, out_eop, out_valid,
        output out_ready
    );

    modport slave (
        input  in_data, in_hdr, in_sop, in_eop, in_valid,
        output in_ready,
        output out_data, out_hdr, out_sop, out_eop, out_valid,
        input  out_ready
    );
endinterface

// File: rtl/tlp_route_demux.sv
// Packet-atomic TLP demultiplexer: steers whole TLPs from one ingress stream to
// PORTS egress streams (2..4) chosen by the fmt/type byte of the SOP header.
// Each egress port has its own registered output stage with valid/ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tlp_route_demux_if.slave (ingress in_*, egress out_*)
//   enable     : admit new packets (in-flight packets always complete)
//   drop_cnt   : saturating count of dropped packets and orphan beats
// Optional feature: define TLP_DEMUX_DROP_EN to discard "other" TLPs (class 3)
// when PORTS < 4 instead of routing them to port PORTS-1.
module tlp_route_demux #(
    parameter int unsigned PORTS        = 4,
    parameter int unsigned DOUBLE_WORD  = 32,
    parameter int unsigned HEADER_SIZE  = 4 * DOUBLE_WORD,
    parameter int unsigned PAYLOAD_SIZE = 8 * DOUBLE_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    tlp_route_demux_if.slave    bus,
    input  logic                enable,
    output logic [15:0]         drop_cnt
);

    localparam int unsigned SEL_W = (PORTS > 2) ? 2 : 1;

`ifdef TLP_DEMUX_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;

    logic [1:0]         cls_c;
    logic [SEL_W-1:0]   tgt_c;
    logic               drop_pkt_c;
    logic               ready_c;
    logic               fwd_c;
    logic               hdr_load_c;
    logic [SEL_W-1:0]   fwd_port_c;
    logic               drop_inc_c;

    // fmt = ft[7:5], type = ft[4:0]
    function automatic logic [1:0] tlp_class(input logic [7:0] ft);
        if (ft[4:0] == 5'b00000 && ft[7:6] == 2'b00) return 2'd0;
        if (ft[4:0] == 5'b00000 && ft[7:6] == 2'b01) return 2'd1;
        if (ft[4:0] == 5'b01010)                     return 2'd2;
        return 2'd3;
    endfunction

    // Classification of the live header; only meaningful on an IDLE SOP beat.
    always_comb begin
        cls_c      = tlp_class(bus.in_hdr[31:24]);
        tgt_c      = (32'(cls_c) < PORTS) ? SEL_W'(cls_c) : SEL_W'(PORTS - 1);
        drop_pkt_c = DROP_EN && (PORTS < 4) && (cls_c == 2'd3);
    end

    // Next-state, ingress ready and forwarding decisions.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ready_c    = 1'b0;
        fwd_c      = 1'b0;
        hdr_load_c = 1'b0;
        fwd_port_c = sel_q;
        drop_inc_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.in_sop) begin
                    // Orphan beat: swallowed and counted.
                    ready_c    = enable;
                    drop_inc_c = bus.in_valid && enable;
                end else if (drop_pkt_c) begin
                    ready_c = enable;
                    if (bus.in_valid && enable) begin
                        drop_inc_c = 1'b1;
                        if (!bus.in_eop) state_d = DROP;
                    end
                end else begin
                    ready_c = enable && (!bus.out_valid[tgt_c] || bus.out_ready[tgt_c]);
                    if (bus.in_valid && ready_c) begin
                        fwd_c      = 1'b1;
                        hdr_load_c = 1'b1;
                        fwd_port_c = tgt_c;
                        sel_d      = tgt_c;
                        if (!bus.in_eop) state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // enable ignored so an in-flight packet always completes.
                ready_c = !bus.out_valid[sel_q] || bus.out_ready[sel_q];
                if (bus.in_valid && ready_c) begin
                    fwd_c = 1'b1;
                    if (bus.in_eop) state_d = IDLE;
                end
            end
            DROP: begin
                ready_c = 1'b1;
                if (bus.in_valid && bus.in_eop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready = rst_n && ready_c;

    // FSM state and latched port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_inc_c && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Per-port egress registers; the header is taken from the SOP beat only
    // and held for the remaining beats of the packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= '0;
            bus.out_sop   <= '0;
            bus.out_eop   <= '0;
            bus.out_data  <= '0;
            bus.out_hdr   <= '0;
        end else begin
            for (int unsigned p = 0; p < PORTS; p++) begin
                if (fwd_c && (fwd_port_c == SEL_W'(p))) begin
                    bus.out_valid[p] <= 1'b1;
                    bus.out_sop[p]   <= hdr_load_c;
                    bus.out_eop[p]   <= bus.in_eop;
                    bus.out_data[p*PAYLOAD_SIZE +: PAYLOAD_SIZE] <= bus.in_data;
                    if (hdr_load_c) begin
                        bus.out_hdr[p*HEADER_SIZE +: HEADER_SIZE] <= bus.in_hdr;
                    end
                end else if (bus.out_ready[p]) begin
                    bus.out_valid[p] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tlp_route_demux.sv
module tb_tlp_route_demux;

    localparam int unsigned HS = 128;
    localparam int unsigned PS = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable;
    logic [15:0] drop_cnt;
    logic [15:0] drop_cnt2;

    int errors = 0;
    int checks = 0;
    int exp_drop = 0;

    typedef struct {
        logic [HS-1:0] hdr;
        logic [PS-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    beat_t exp_q[4][$];

    tlp_route_demux_if #(.PORTS(4), .HEADER_SIZE(HS), .PAYLOAD_SIZE(PS)) bus ();
    tlp_route_demux_if #(.PORTS(2), .HEADER_SIZE(HS), .PAYLOAD_SIZE(PS)) bus2 ();

    tlp_route_demux #(.PORTS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus), .enable(enable), .drop_cnt(drop_cnt)
    );

    tlp_route_demux #(.PORTS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .enable(enable), .drop_cnt(drop_cnt2)
    );

    always #5 clk = ~clk;

    // Reference routing: port chosen from the TLP class, -1 when discarded.
    function automatic int exp_port(input logic [7:0] ft, input int ports);
        logic [2:0] fmt;
        logic [4:0] typ;
        int cls;
        fmt = ft[7:5];
        typ = ft[4:0];
        if (typ == 5'd0 && (fmt == 3'd0 || fmt == 3'd1))      cls = 0;
        else if (typ == 5'd0 && (fmt == 3'd2 || fmt == 3'd3)) cls = 1;
        else if (typ == 5'b01010)                             cls = 2;
        else                                                  cls = 3;
`ifdef TLP_DEMUX_DROP_EN
        if (cls == 3 && ports < 4) return -1;
`endif
        return (cls < ports) ? cls : ports - 1;
    endfunction

    function automatic logic [HS-1:0] rand_hdr(input logic [7:0] ft);
        logic [HS-1:0] h;
        for (int i = 0; i < HS / 32; i++) h[i*32 +: 32] = $urandom;
        h[31:24] = ft;
        return h;
    endfunction

    function automatic logic [PS-1:0] rand_data();
        logic [PS-1:0] d;
        for (int i = 0; i < PS / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic send_beat(input logic [HS-1:0] h, input logic [PS-1:0] d,
                             input logic sop, input logic eop, output bit ok);
        int n = 0;
        bus.in_hdr = h; bus.in_data = d; bus.in_sop = sop; bus.in_eop = eop;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 300);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_beat_timeout: got in_ready=%b after %0d cycles, expected 1", bus.in_ready, n);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] ft, input int len);
        logic [HS-1:0] h;
        logic [PS-1:0] d;
        int  port;
        bit  ok;
        beat_t b;
        port = exp_port(ft, 4);
        h = rand_hdr(ft);
        for (int i = 0; i < len; i++) begin
            d = rand_data();
            send_beat((i == 0) ? h : rand_hdr(8'($urandom)), d, i == 0, i == len - 1, ok);
            if (ok && port >= 0) begin
                b.hdr = h; b.data = d; b.sop = (i == 0); b.eop = (i == len - 1);
                exp_q[port].push_back(b);
            end
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1; bus.in_sop = 1'b1; bus.in_eop = 1'b1;
        bus.in_hdr = rand_hdr(8'h00); bus.in_data = rand_data();
        bus.out_ready = '0; enable = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 4'b0 || bus.out_sop !== 4'b0 || bus.out_eop !== 4'b0) begin errors++; $display("FAIL reset_flags: got v=%b s=%b e=%b expected 0", bus.out_valid, bus.out_sop, bus.out_eop); end
        checks++; if (bus.out_data !== '0 || bus.out_hdr !== '0) begin errors++; $display("FAIL reset_data: got nonzero data/hdr expected 0"); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_mrd();
        logic [HS-1:0] h;
        logic [PS-1:0] d;
        h = rand_hdr(8'h00); d = rand_data();
        bus.out_ready = 4'b0000;
        bus.in_hdr = h; bus.in_data = d; bus.in_sop = 1'b1; bus.in_eop = 1'b1; bus.in_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mrd_in_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1; bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b0001) begin errors++; $display("FAIL mrd_valid: got %b expected 0001", bus.out_valid); end
        checks++; if (bus.out_hdr[0 +: HS] !== h || bus.out_data[0 +: PS] !== d) begin errors++; $display("FAIL mrd_payload: got hdr %h expected %h", bus.out_hdr[0 +: HS], h); end
        checks++; if (bus.out_sop[0] !== 1'b1 || bus.out_eop[0] !== 1'b1) begin errors++; $display("FAIL mrd_flags: got sop=%b eop=%b expected 1 1", bus.out_sop[0], bus.out_eop[0]); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b0001 || bus.out_data[0 +: PS] !== d) begin errors++; $display("FAIL mrd_hold: got valid %b expected 0001 with stable data", bus.out_valid); end
        bus.out_ready = 4'b1111;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL mrd_drain: got %b expected 0000", bus.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        logic [HS-1:0] h;
        logic [PS-1:0] d0, d1, d2;
        h = rand_hdr(8'h40); d0 = rand_data(); d1 = rand_data(); d2 = rand_data();
        bus.out_ready = 4'b1101;
        bus.in_hdr = h; bus.in_data = d0; bus.in_sop = 1'b1; bus.in_eop = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_first_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_hdr = rand_hdr(8'h00); bus.in_data = d1; bus.in_sop = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_low1: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_valid[1] !== 1'b1 || bus.out_data[PS +: PS] !== d0 || bus.out_sop[1] !== 1'b1) begin errors++; $display("FAIL stall_beat0: got v=%b sop=%b data %h expected 1 1 %h", bus.out_valid[1], bus.out_sop[1], bus.out_data[PS +: PS], d0); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_low2: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_data[PS +: PS] !== d0 || bus.out_valid[1] !== 1'b1) begin errors++; $display("FAIL stall_hold: got %h expected %h", bus.out_data[PS +: PS], d0); end
        @(posedge clk); #1; bus.out_ready = 4'b1111;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_data = d2; bus.in_eop = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid[1] !== 1'b1 || bus.out_data[PS +: PS] !== d1 || bus.out_sop[1] !== 1'b0 || bus.out_eop[1] !== 1'b0 || bus.out_hdr[HS +: HS] !== h) begin errors++; $display("FAIL stall_beat1: got v=%b s=%b e=%b data %h expected 1 0 0 %h", bus.out_valid[1], bus.out_sop[1], bus.out_eop[1], bus.out_data[PS +: PS], d1); end
        @(posedge clk); #1; bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b0010 || bus.out_data[PS +: PS] !== d2 || bus.out_sop[1] !== 1'b0 || bus.out_eop[1] !== 1'b1) begin errors++; $display("FAIL stall_beat2: got v=%b s=%b e=%b data %h expected 0010 0 1 %h", bus.out_valid, bus.out_sop[1], bus.out_eop[1], bus.out_data[PS +: PS], d2); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL stall_drain: got %b expected 0000", bus.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [HS-1:0] h[4];
        logic [HS-1:0] eh[4];
        logic [PS-1:0] d[4];
        int   pt[4];
        logic s[4];
        logic e[4];
        eh[0] = rand_hdr(8'h4A); eh[1] = eh[0];
        eh[2] = rand_hdr(8'h00); eh[3] = eh[2];
        h[0] = eh[0]; h[1] = rand_hdr(8'h00); h[2] = eh[2]; h[3] = rand_hdr(8'h4A);
        pt[0] = exp_port(8'h4A, 4); pt[1] = pt[0]; pt[2] = exp_port(8'h00, 4); pt[3] = pt[2];
        s = '{1'b1, 1'b0, 1'b1, 1'b0};
        e = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) d[k] = rand_data();
        bus.out_ready = 4'b1111;
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) begin
                bus.in_hdr = h[k]; bus.in_data = d[k]; bus.in_sop = s[k]; bus.in_eop = e[k]; bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 4) begin
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready beat %0d: got %b expected 1", k, bus.in_ready); end
            end
            if (k > 0) begin
                checks++;
                if (bus.out_valid !== 4'(1 << pt[k-1]) || bus.out_data[pt[k-1]*PS +: PS] !== d[k-1] ||
                    bus.out_hdr[pt[k-1]*HS +: HS] !== eh[k-1] || bus.out_sop[pt[k-1]] !== s[k-1] || bus.out_eop[pt[k-1]] !== e[k-1]) begin
                    errors++; $display("FAIL b2b_out beat %0d: got valid %b expected port %0d", k - 1, bus.out_valid, pt[k-1]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_enable();
        logic [HS-1:0] h, hm;
        h = rand_hdr(8'h40); hm = rand_hdr(8'h00);
        bus.out_ready = 4'b1111; enable = 1'b1;
        bus.in_hdr = h; bus.in_data = rand_data(); bus.in_sop = 1'b1; bus.in_eop = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL en_sop_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1;
        enable = 1'b0; bus.in_sop = 1'b0; bus.in_data = rand_data();
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL en_busy1: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_eop = 1'b1; bus.in_data = rand_data();
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL en_busy2: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_hdr = hm; bus.in_sop = 1'b1; bus.in_eop = 1'b1; bus.in_data = rand_data();
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL en_idle_stall1: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 4'b0010 || bus.out_eop[1] !== 1'b1) begin errors++; $display("FAIL en_pkt_done: got v=%b eop=%b expected 0010 1", bus.out_valid, bus.out_eop[1]); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 4'b0000) begin errors++; $display("FAIL en_idle_stall2: got ready=%b v=%b expected 0 0000", bus.in_ready, bus.out_valid); end
        @(posedge clk); #1; enable = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL en_resume: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1; bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b0001 || bus.out_hdr[0 +: HS] !== hm) begin errors++; $display("FAIL en_next_pkt: got v=%b expected 0001", bus.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_ports2();
        logic [HS-1:0] h[5];
        logic [HS-1:0] eh[5];
        logic [PS-1:0] d[5];
        int   pt[5];
        logic s[5];
        logic e[5];
        int   exp_d2;
        eh[0] = rand_hdr(8'h30); eh[1] = eh[0];
        eh[2] = rand_hdr(8'h00); eh[3] = rand_hdr(8'h4A); eh[4] = rand_hdr(8'h60);
        h[0] = eh[0]; h[1] = rand_hdr(8'($urandom)); h[2] = eh[2]; h[3] = eh[3]; h[4] = eh[4];
        pt[0] = exp_port(8'h30, 2); pt[1] = pt[0];
        pt[2] = exp_port(8'h00, 2); pt[3] = exp_port(8'h4A, 2); pt[4] = exp_port(8'h60, 2);
        s = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        e = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_d2 = (pt[0] < 0) ? 1 : 0;
        for (int k = 0; k < 5; k++) d[k] = rand_data();
        bus2.out_ready = 2'b11; enable = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            if (k < 5) begin
                bus2.in_hdr = h[k]; bus2.in_data = d[k]; bus2.in_sop = s[k]; bus2.in_eop = e[k]; bus2.in_valid = 1'b1;
            end else begin
                bus2.in_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 5) begin
                checks++; if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL p2_ready beat %0d: got %b expected 1", k, bus2.in_ready); end
            end
            if (k > 0 && pt[k-1] < 0) begin
                checks++; if (bus2.out_valid !== 2'b00) begin errors++; $display("FAIL p2_dropped beat %0d: got valid %b expected 00", k - 1, bus2.out_valid); end
            end else if (k > 0) begin
                checks++;
                if (bus2.out_valid !== 2'(1 << pt[k-1]) || bus2.out_data[pt[k-1]*PS +: PS] !== d[k-1] ||
                    bus2.out_hdr[pt[k-1]*HS +: HS] !== eh[k-1] || bus2.out_sop[pt[k-1]] !== s[k-1] || bus2.out_eop[pt[k-1]] !== e[k-1]) begin
                    errors++; $display("FAIL p2_out beat %0d: got valid %b expected port %0d", k - 1, bus2.out_valid, pt[k-1]);
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (drop_cnt2 !== 16'(exp_d2)) begin errors++; $display("FAIL p2_drop_cnt: got %0d expected %0d", drop_cnt2, exp_d2); end
    endtask

    task automatic test_random();
        logic [7:0] fts[8];
        bit  done;
        bit  ok;
        int  cyc;
        beat_t b;
        fts = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h4A, 8'h0A, 8'h30, 8'h04};
        done = 1'b0;
        cyc = 0;
        enable = 1'b1;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        send_beat(rand_hdr(8'($urandom)), rand_data(), 1'b0, 1'($urandom_range(0, 1)), ok);
                        if (ok) exp_drop++;
                    end
                    send_pkt(fts[$urandom_range(0, 7)], int'($urandom_range(1, 4)));
                end
                done = 1'b1;
            end
            begin
                while (!(done && exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
                         exp_q[2].size() == 0 && exp_q[3].size() == 0) && cyc < 20000) begin
                    @(posedge clk); #1;
                    for (int p = 0; p < 4; p++) bus.out_ready[p] = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    for (int p = 0; p < 4; p++) begin
                        if (bus.out_valid[p] && bus.out_ready[p]) begin
                            checks++;
                            if (exp_q[p].size() == 0) begin
                                errors++; $display("FAIL rand_unexpected port %0d: got beat data %h expected none", p, bus.out_data[p*PS +: PS]);
                            end else begin
                                b = exp_q[p].pop_front();
                                if (bus.out_data[p*PS +: PS] !== b.data || bus.out_hdr[p*HS +: HS] !== b.hdr ||
                                    bus.out_sop[p] !== b.sop || bus.out_eop[p] !== b.eop) begin
                                    errors++; $display("FAIL rand_beat port %0d: got sop=%b eop=%b hdr=%h data=%h expected sop=%b eop=%b hdr=%h data=%h",
                                        p, bus.out_sop[p], bus.out_eop[p], bus.out_hdr[p*HS +: HS], bus.out_data[p*PS +: PS], b.sop, b.eop, b.hdr, b.data);
                                end
                            end
                        end
                    end
                    cyc++;
                end
            end
        join
        checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_drain_timeout: got %0d cycles expected fewer than 20000", cyc); end
        bus.out_ready = 4'b1111;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL rand_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop); end
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL rand_idle: got %b expected 0000", bus.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_orphan_reset();
        logic [HS-1:0] hm;
        bus.out_ready = 4'b1111; enable = 1'b1;
        bus.in_hdr = rand_hdr(8'h00); bus.in_data = rand_data(); bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL orphan_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1; bus.in_valid = 1'b0; exp_drop++;
        @(negedge clk);
        checks++; if (drop_cnt !== 16'(exp_drop) || bus.out_valid !== 4'b0) begin errors++; $display("FAIL orphan_count: got cnt=%0d v=%b expected %0d 0000", drop_cnt, bus.out_valid, exp_drop); end
        @(posedge clk); #1;
        bus.in_hdr = rand_hdr(8'h40); bus.in_data = rand_data(); bus.in_sop = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_hdr = rand_hdr(8'h00); bus.in_data = rand_data(); bus.in_sop = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 4'b0 || bus.out_sop !== 4'b0 || bus.out_eop !== 4'b0 || bus.out_data !== '0 || bus.out_hdr !== '0) begin errors++; $display("FAIL midreset_outputs: got v=%b expected all outputs 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL midreset_ready_cnt: got ready=%b cnt=%0d expected 0 0", bus.in_ready, drop_cnt); end
        exp_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL postreset_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1; exp_drop++;
        bus.in_data = rand_data(); bus.in_eop = 1'b1;
        @(negedge clk);
        checks++; if (drop_cnt !== 16'(exp_drop) || bus.out_valid !== 4'b0) begin errors++; $display("FAIL postreset_orphan1: got cnt=%0d v=%b expected %0d 0000", drop_cnt, bus.out_valid, exp_drop); end
        @(posedge clk); #1; exp_drop++;
        hm = rand_hdr(8'h00);
        bus.in_hdr = hm; bus.in_data = rand_data(); bus.in_sop = 1'b1; bus.in_eop = 1'b1;
        @(negedge clk);
        checks++; if (drop_cnt !== 16'(exp_drop) || bus.out_valid !== 4'b0) begin errors++; $display("FAIL postreset_orphan2: got cnt=%0d v=%b expected %0d 0000", drop_cnt, bus.out_valid, exp_drop); end
        @(posedge clk); #1; bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 4'b0001 || bus.out_hdr[0 +: HS] !== hm) begin errors++; $display("FAIL postreset_idle_route: got v=%b expected 0001", bus.out_valid); end
        @(posedge clk); #1;
    endtask

    initial begin
        enable = 1'b0;
        bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
        bus.in_hdr = '0; bus.in_data = '0; bus.out_ready = '0;
        bus2.in_valid = 1'b0; bus2.in_sop = 1'b0; bus2.in_eop = 1'b0;
        bus2.in_hdr = '0; bus2.in_data = '0; bus2.out_ready = 2'b11;
        test_reset();
        test_single_mrd();
        test_stall();
        test_back_to_back();
        test_enable();
        test_ports2();
        test_random();
        test_orphan_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
